// File: rtl/padring_pkg.sv
// Shared definitions for the ui/uo pad ring datapath.
//   PAD_W       pads per direction on this pad ring
//   mode_e      loopback test pattern selector
//   CHK_EVEN/   checkerboard patterns at PAD_W (bit0 set first)
//   CHK_ODD
//   state_e     loopback sequencer states
package padring_pkg;

   localparam int unsigned PAD_W = 10;

   typedef enum logic [1:0] {
      ModeWalk1   = 2'd0,
      ModeWalk0   = 2'd1,
      ModeCount   = 2'd2,
      ModeChecker = 2'd3
   } mode_e;

   localparam logic [PAD_W-1:0] CHK_EVEN = 10'h155;
   localparam logic [PAD_W-1:0] CHK_ODD  = 10'h2AA;

   typedef enum logic [2:0] {
      StIdle,
      StDrive,
      StSettle,
      StSample,
      StDone
   } state_e;

endpackage

// File: rtl/pad_sync.sv
// Per-bit synchroniser chain for asynchronous input-pad values.
//   clk      clock
//   rst      synchronous reset, active-high; clears every stage to 0
//   async_i  raw pad values (asynchronous to clk)
//   sync_o   values after STAGES flops
module pad_sync
   import padring_pkg::*;
#(
   parameter int unsigned WIDTH  = PAD_W,
   parameter int unsigned STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] async_i,
   output logic [WIDTH-1:0] sync_o
);

   logic [WIDTH-1:0] chain_q [STAGES];

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < int'(STAGES); s++) begin
            chain_q[s] <= '0;
         end
      end else begin
         chain_q[0] <= async_i;
         for (int s = 1; s < int'(STAGES); s++) begin
            chain_q[s] <= chain_q[s-1];
         end
      end
   end

   assign sync_o = chain_q[STAGES-1];

endmodule

// File: rtl/pad_loopback_seq.sv
// Pad ring loopback sequencer. Owns the output-pad drive mux: core data passes
// through when idle; during a test run the pads are driven with a pattern
// sequence and the looped-back input pads are sampled and compared.
//   clk, rst       clock; synchronous active-high reset
//   start_i        begin a run (accepted only when idle)
//   abort_i        abandon a run in progress
//   mode_i         0 walk-1, 1 walk-0, 2 binary count, 3 checkerboard
//   core_uo_i      functional output data from the core
//   ui_p2c_i       raw input-pad values
//   uo_c2p_o       output-pad drive
//   ui_sync_o      synchronised input-pad values for the core
//   busy_o         run in progress
//   done_o         single-cycle pulse when a run completes
//   pass_o         last completed run saw no mismatch
//   err_count_o    mismatching patterns, saturating at 255
//   fail_idx_o     pattern index of the first mismatch
//   fail_vec_o     expected XOR sampled at the first mismatch
module pad_loopback_seq
   import padring_pkg::*;
#(
   parameter int unsigned WIDTH         = PAD_W,
   parameter int unsigned SYNC_STAGES   = 2,
   parameter int unsigned SETTLE_CYCLES = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic             abort_i,
   input  logic [1:0]       mode_i,
   input  logic [WIDTH-1:0] core_uo_i,
   input  logic [WIDTH-1:0] ui_p2c_i,
   output logic [WIDTH-1:0] uo_c2p_o,
   output logic [WIDTH-1:0] ui_sync_o,
   output logic             busy_o,
   output logic             done_o,
   output logic             pass_o,
   output logic [7:0]       err_count_o,
   output logic [WIDTH-1:0] fail_idx_o,
   output logic [WIDTH-1:0] fail_vec_o
);

   localparam int unsigned     CntW       = $clog2(SETTLE_CYCLES + 1);
   localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);

   state_e           state_q, state_d;
   mode_e            mode_q, mode_d;
   logic [WIDTH-1:0] idx_q, idx_d;
   logic [WIDTH-1:0] pat_q, pat_d;
   logic [CntW-1:0]  cnt_q, cnt_d;
   logic [7:0]       err_q, err_d;
   logic [WIDTH-1:0] fail_idx_q, fail_idx_d;
   logic [WIDTH-1:0] fail_vec_q, fail_vec_d;
   logic             pass_q, pass_d;

   logic [WIDTH-1:0] pat_gen, last_idx, chk_even, diff;

   pad_sync #(
      .WIDTH  (WIDTH),
      .STAGES (SYNC_STAGES)
   ) u_ui_sync (
      .clk     (clk),
      .rst     (rst),
      .async_i (ui_p2c_i),
      .sync_o  (ui_sync_o)
   );

   // Pattern for the current index and the final index of the latched mode.
   always_comb begin
      pat_gen  = '0;
      last_idx = '0;
      chk_even = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         chk_even[i] = (i % 2) == 0;
      end
      unique case (mode_q)
         ModeWalk1: begin
            pat_gen  = WIDTH'(1) << idx_q;
            last_idx = WIDTH'(WIDTH - 1);
         end
         ModeWalk0: begin
            pat_gen  = ~(WIDTH'(1) << idx_q);
            last_idx = WIDTH'(WIDTH - 1);
         end
         ModeCount: begin
            pat_gen  = idx_q;
            last_idx = '1;
         end
         ModeChecker: begin
            pat_gen  = idx_q[0] ? ~chk_even : chk_even;
            last_idx = WIDTH'(1);
         end
         default: ;
      endcase
   end

   always_comb begin
      state_d    = state_q;
      mode_d     = mode_q;
      idx_d      = idx_q;
      pat_d      = pat_q;
      cnt_d      = cnt_q;
      err_d      = err_q;
      fail_idx_d = fail_idx_q;
      fail_vec_d = fail_vec_q;
      pass_d     = pass_q;
      diff       = ui_sync_o ^ pat_q;

      unique case (state_q)
         StIdle: begin
            if (start_i) begin
               mode_d     = mode_e'(mode_i);
               err_d      = '0;
               fail_idx_d = '0;
               fail_vec_d = '0;
               pass_d     = 1'b0;
               idx_d      = '0;
               state_d    = StDrive;
            end
         end
         StDrive: begin
            pat_d   = pat_gen;
            cnt_d   = SettleLoad;
            state_d = StSettle;
         end
         StSettle: begin
            if (cnt_q == '0) begin
               state_d = StSample;
            end else begin
               cnt_d = cnt_q - CntW'(1);
            end
         end
         StSample: begin
            if (diff != '0) begin
               if (err_q != 8'hFF) begin
                  err_d = err_q + 8'd1;
               end
               if (err_q == 8'd0) begin
                  fail_idx_d = idx_q;
                  fail_vec_d = diff;
               end
            end
            if (idx_q == last_idx) begin
               // pass is valid during the DONE cycle, so it reflects this sample.
               pass_d  = (err_d == 8'd0);
               state_d = StDone;
            end else begin
               idx_d   = idx_q + WIDTH'(1);
               state_d = StDrive;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      // Abort beats every transition, including a compare in progress.
      if (state_q != StIdle && abort_i) begin
         state_d    = StIdle;
         pass_d     = 1'b0;
         err_d      = err_q;
         fail_idx_d = fail_idx_q;
         fail_vec_d = fail_vec_q;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         mode_q     <= ModeWalk1;
         idx_q      <= '0;
         pat_q      <= '0;
         cnt_q      <= '0;
         err_q      <= '0;
         fail_idx_q <= '0;
         fail_vec_q <= '0;
         pass_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         idx_q      <= idx_d;
         pat_q      <= pat_d;
         cnt_q      <= cnt_d;
         err_q      <= err_d;
         fail_idx_q <= fail_idx_d;
         fail_vec_q <= fail_vec_d;
         pass_q     <= pass_d;
      end
   end

   assign uo_c2p_o    = (state_q == StIdle || state_q == StDone) ? core_uo_i : pat_q;
   assign busy_o      = (state_q == StDrive) || (state_q == StSettle) || (state_q == StSample);
   assign done_o      = (state_q == StDone) && !abort_i;
   assign pass_o      = pass_q;
   assign err_count_o = err_q;
   assign fail_idx_o  = fail_idx_q;
   assign fail_vec_o  = fail_vec_q;

endmodule

// File: tb/tb_pad_loopback_seq.sv
// Bench for pad_loopback_seq: board loopback uo->ui with injectable faults
// (stuck-at masks, bit0/bit1 wired-AND short), a table of directed runs,
// randomised runs against a pattern-list reference model, and hand-written
// abort / reset / start-while-busy sequences.
module tb_pad_loopback_seq;

   localparam int W = 10;

   logic         clk = 1'b0;
   logic         rst, start_i, abort_i;
   logic [1:0]   mode_i;
   logic [W-1:0] core_uo_i, ui_p2c_i, uo_c2p_o, ui_sync_o;
   logic         busy_o, done_o, pass_o;
   logic [7:0]   err_count_o;
   logic [W-1:0] fail_idx_o, fail_vec_o;

   logic [W-1:0] s0_mask = '0;
   logic [W-1:0] s1_mask = '0;
   logic         short01 = 1'b0;

   int n_vec = 0;
   int n_bad = 0;
   int done_pulses = 0;

   pad_loopback_seq #(
      .WIDTH         (W),
      .SYNC_STAGES   (2),
      .SETTLE_CYCLES (4)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .abort_i     (abort_i),
      .mode_i      (mode_i),
      .core_uo_i   (core_uo_i),
      .ui_p2c_i    (ui_p2c_i),
      .uo_c2p_o    (uo_c2p_o),
      .ui_sync_o   (ui_sync_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .pass_o      (pass_o),
      .err_count_o (err_count_o),
      .fail_idx_o  (fail_idx_o),
      .fail_vec_o  (fail_vec_o)
   );

   always #5 clk = ~clk;

   // Board wiring between the output and input pads, with faults.
   function automatic logic [W-1:0] board(input logic [W-1:0] v, input logic [W-1:0] s0,
                                          input logic [W-1:0] s1, input logic sh);
      logic [W-1:0] r;
      r = v;
      if (sh) begin
         r[0] = v[0] & v[1];
         r[1] = v[0] & v[1];
      end
      return (r & ~s0) | s1;
   endfunction

   always_comb ui_p2c_i = board(uo_c2p_o, s0_mask, s1_mask, short01);

   always @(posedge clk) if (done_o) done_pulses++;

   function automatic logic [W-1:0] pattern(input logic [1:0] mode, input int idx);
      logic [W-1:0] one;
      one = 1;
      case (mode)
         2'd0:    return one << idx;
         2'd1:    return ~(one << idx);
         2'd2:    return W'(idx);
         default: return (idx % 2 == 1) ? 10'h2AA : 10'h155;
      endcase
   endfunction

   function automatic int num_patterns(input logic [1:0] mode);
      case (mode)
         2'd0, 2'd1: return W;
         2'd2:       return 1 << W;
         default:    return 2;
      endcase
   endfunction

   // Reference: walk the whole pattern list through the faulty board.
   task automatic model(input logic [1:0] mode, input logic [W-1:0] s0, input logic [W-1:0] s1,
                        input logic sh, output int err, output int fidx, output int fvec,
                        output int pass, output int lat);
      logic [W-1:0] p, x;
      err = 0; fidx = 0; fvec = 0;
      for (int i = 0; i < num_patterns(mode); i++) begin
         p = pattern(mode, i);
         x = p ^ board(p, s0, s1, sh);
         if (x != '0) begin
            if (err == 0) begin
               fidx = i;
               fvec = int'(x);
            end
            if (err < 255) err++;
         end
      end
      pass = (err == 0) ? 1 : 0;
      lat  = 1 + num_patterns(mode) * 6;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got 'h%0h, expected 'h%0h", name, act, exp);
      end
   endtask

   task automatic launch(input logic [1:0] mode);
      mode_i  = mode;
      start_i = 1'b1;
      step();
      start_i = 1'b0;
      chk("busy after start", int'(busy_o), 1);
   endtask

   task automatic finish_run(input string name, input int lat0, input int e_err, input int e_fidx,
                             input int e_fvec, input int e_pass, input int e_lat);
      int lat;
      lat = lat0;
      while (done_o !== 1'b1 && lat < 7000) begin
         step();
         lat++;
      end
      chk({name, " done latency"}, lat, e_lat);
      chk({name, " err_count"}, int'(err_count_o), e_err);
      chk({name, " fail_idx"}, int'(fail_idx_o), e_fidx);
      chk({name, " fail_vec"}, int'(fail_vec_o), e_fvec);
      chk({name, " pass"}, int'(pass_o), e_pass);
      chk({name, " busy in done"}, int'(busy_o), 0);
      chk({name, " mux in done"}, int'(uo_c2p_o), int'(core_uo_i));
      step();
      chk({name, " done one cycle"}, int'(done_o), 0);
      chk({name, " pass holds"}, int'(pass_o), e_pass);
   endtask

   typedef struct {
      string        name;
      logic [1:0]   mode;
      logic [W-1:0] s0;
      logic [W-1:0] s1;
      logic         sh;
      int           err;
      int           fidx;
      int           fvec;
      int           pass;
      int           lat;
   } vec_t;

   vec_t tbl[7];

   initial begin
      int e_err, e_fidx, e_fvec, e_pass, e_lat, snap;
      logic [1:0] m;

      tbl[0] = '{"walk1 clean",      2'd0, 10'h000, 10'h000, 1'b0,   0, 0, 'h000, 1, 61};
      tbl[1] = '{"walk1 bit3 sa0",   2'd0, 10'h008, 10'h000, 1'b0,   1, 3, 'h008, 0, 61};
      tbl[2] = '{"checker short01",  2'd3, 10'h000, 10'h000, 1'b1,   2, 0, 'h001, 0, 13};
      tbl[3] = '{"walk0 bit9 sa1",   2'd1, 10'h000, 10'h200, 1'b0,   1, 9, 'h200, 0, 61};
      tbl[4] = '{"count ui tied 0",  2'd2, 10'h3FF, 10'h000, 1'b0, 255, 1, 'h001, 0, 6145};
      tbl[5] = '{"checker clean",    2'd3, 10'h000, 10'h000, 1'b0,   0, 0, 'h000, 1, 13};
      tbl[6] = '{"walk0 bit0 sa0",   2'd1, 10'h001, 10'h000, 1'b0,   9, 1, 'h001, 0, 61};

      rst = 1'b1; start_i = 1'b0; abort_i = 1'b0; mode_i = 2'd0; core_uo_i = '0;
      repeat (3) step();
      rst = 1'b0;
      chk("reset busy", int'(busy_o), 0);
      chk("reset done", int'(done_o), 0);
      chk("reset pass", int'(pass_o), 0);
      chk("reset err", int'(err_count_o), 0);
      chk("reset fail_idx", int'(fail_idx_o), 0);
      chk("reset fail_vec", int'(fail_vec_o), 0);
      chk("reset ui_sync", int'(ui_sync_o), 0);

      // Idle passthrough is combinational; ui_sync follows two edges later.
      core_uo_i = 10'h2A5;
      #1;
      chk("idle passthrough", int'(uo_c2p_o), 'h2A5);
      repeat (2) step();
      chk("ui_sync after 2 edges", int'(ui_sync_o), 'h2A5);

      for (int i = 0; i < 7; i++) begin
         s0_mask = tbl[i].s0; s1_mask = tbl[i].s1; short01 = tbl[i].sh;
         launch(tbl[i].mode);
         finish_run(tbl[i].name, 1, tbl[i].err, tbl[i].fidx, tbl[i].fvec, tbl[i].pass, tbl[i].lat);
      end

      // Randomised runs against the reference model.
      for (int r = 0; r < 10; r++) begin
         m = (r == 9) ? 2'd2 : ((r % 3 == 2) ? 2'd3 : 2'(r % 3));
         s0_mask = W'($urandom & $urandom & $urandom);
         s1_mask = W'($urandom & $urandom & $urandom) & ~s0_mask;
         short01 = ($urandom_range(0, 3) == 0);
         core_uo_i = W'($urandom);
         model(m, s0_mask, s1_mask, short01, e_err, e_fidx, e_fvec, e_pass, e_lat);
         launch(m);
         finish_run("random run", 1, e_err, e_fidx, e_fvec, e_pass, e_lat);
         core_uo_i = W'($urandom);
         #1;
         chk("random idle passthrough", int'(uo_c2p_o), int'(core_uo_i));
      end
      s0_mask = '0; s1_mask = '0; short01 = 1'b0;

      // start and a mode change while busy must not disturb the walk-1 run.
      launch(2'd0);
      repeat (20) step();
      mode_i = 2'd3; start_i = 1'b1;
      step();
      start_i = 1'b0;
      finish_run("start while busy", 22, 0, 0, 0, 1, 61);

      // Abort during SETTLE of index 5 keeps partial error state.
      s0_mask = 10'h008;
      launch(2'd0);
      repeat (32) step();
      chk("busy before abort", int'(busy_o), 1);
      snap = done_pulses;
      abort_i = 1'b1;
      step();
      abort_i = 1'b0;
      core_uo_i = 10'h13C;
      #1;
      chk("abort busy", int'(busy_o), 0);
      chk("abort mux", int'(uo_c2p_o), 'h13C);
      chk("abort pass", int'(pass_o), 0);
      chk("abort err kept", int'(err_count_o), 1);
      chk("abort fail_idx kept", int'(fail_idx_o), 3);
      chk("abort fail_vec kept", int'(fail_vec_o), 'h008);
      repeat (80) step();
      chk("abort no done", done_pulses, snap);

      // Reset during SAMPLE of index 4, then a clean run.
      launch(2'd0);
      repeat (29) step();
      chk("partial err before reset", int'(err_count_o), 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mid-run reset busy", int'(busy_o), 0);
      chk("mid-run reset done", int'(done_o), 0);
      chk("mid-run reset err", int'(err_count_o), 0);
      chk("mid-run reset fail_idx", int'(fail_idx_o), 0);
      chk("mid-run reset fail_vec", int'(fail_vec_o), 0);
      chk("mid-run reset ui_sync", int'(ui_sync_o), 0);
      chk("mid-run reset mux", int'(uo_c2p_o), int'(core_uo_i));
      s0_mask = '0;
      launch(2'd0);
      finish_run("run after reset", 1, 0, 0, 0, 1, 61);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
